if_stage_imem: RTL

//  Fetch stage fed by the PC register: instruction memory plus IF/ID pipeline register.

---
 rtl/if_stage_imem.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/if_stage_imem.sv
// Fetch stage: byte-loaded instruction memory + IF/ID register (1-cycle latency from i_PC),
// stalls on i_IF_ID_write=0, flush/halt insert bubbles; `IMEM_READBACK_EN adds a debug read port.
module if_stage_imem #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_PC,
  input  logic              i_IF_ID_write,
  input  logic              i_flush,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_PC_plus4,
  output logic              o_valid,
  output logic              o_halt,
  output logic              o_load_done,
  output logic              o_loading
`ifdef IMEM_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_word
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic [31:0]       asm_word;
  logic              mem_we;
  logic              load_last;

  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              halt_q, halt_d;
  logic [31:0]       rd_word;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^i_PC[1:0];

  // ---------------- load FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- load FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (i_load_start) state_d = LOADING;
      end
      LOADING: begin
        if (i_load_start)   state_d = LOADING;
        else if (load_last) state_d = RUN;
      end
      RUN: begin
        if (i_load_start) state_d = LOADING;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---------------- load FSM: outputs ----------------
  always_comb begin
    o_load_done = (state_q == RUN);
    o_loading   = (state_q == LOADING);
  end

  // ---------------- byte assembly datapath ----------------
  assign asm_word = {word_buf_q, i_load_byte};

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    load_addr_d = load_addr_q;
    word_buf_d  = word_buf_q;
    mem_we      = 1'b0;
    load_last   = 1'b0;
    if (i_load_start) begin
      // restart drops any partially assembled word
      byte_cnt_d  = 2'd0;
      load_addr_d = '0;
    end else if (state_q == LOADING && i_load_valid) begin
      word_buf_d = asm_word[23:0];
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        mem_we      = 1'b1;
        load_addr_d = load_addr_q + 1'b1;
        load_last   = (asm_word == HALT_WORD) ||
                      (load_addr_q == ADDR_W'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= 2'd0;
      load_addr_q <= '0;
      word_buf_q  <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      load_addr_q <= load_addr_d;
      word_buf_q  <= word_buf_d;
    end
  end

  // contents survive reset; only the loader writes
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr_q] <= asm_word;
  end

  // ---------------- fetch read + IF/ID register ----------------
  always_comb begin
    if (|i_PC[31:ADDR_W+2]) rd_word = NOP_WORD;
    else                    rd_word = mem[i_PC[ADDR_W+1:2]];
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    if (state_q != RUN || i_load_start) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      if (i_load_start) halt_d = 1'b0;
    end else if (halt_q || i_flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (i_IF_ID_write) begin
      instr_d = rd_word;
      pc4_d   = i_PC + 32'd4;
      valid_d = 1'b1;
      halt_d  = (rd_word == HALT_WORD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_PC_plus4 = pc4_q;
  assign o_valid    = valid_q;
  assign o_halt     = halt_q;

`ifdef IMEM_READBACK_EN
  assign o_dbg_word = mem[i_dbg_addr];
`endif

endmodule
